// File: rtl/dot_pkg.sv
// dot_pkg: shared state encoding, tree depth and lane-slice helper for the dot-product engine
package dot_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, REDUCE, OUT} state_t;
  localparam int P_DEF = 8;
  localparam int L_DEF = $clog2(P_DEF);
  function automatic int tree_levels(input int p);
    return $clog2(p);
  endfunction
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: registered pairwise reduction of P lanes, one level per cycle
module adder_tree_pipe
  import dot_pkg::*;
#(
  parameter int P     = 8,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [P*ACC_W-1:0] i_data,
  output logic               o_last,
  output logic [ACC_W-1:0]   o_data
);
  localparam int L = tree_levels(P);
  // Heap layout: node n sums nodes 2n and 2n+1; leaves P..2P-1 are the inputs.
  logic [ACC_W-1:0] r_node [1:P-1];
  logic [ACC_W-1:0] w_node [1:2*P-1];
  // The flag enters with the final accumulate, so r_vld[L-1] marks the cycle the root captures.
  logic [L-1:0]     r_vld;
  always_comb begin
    for (int n = 1; n < P; n++) w_node[n] = r_node[n];
    for (int n = 0; n < P; n++) w_node[P+n] = i_data[lane_lsb(n, ACC_W) +: ACC_W];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clear) begin
      r_vld <= '0;
      for (int n = 1; n < P; n++) r_node[n] <= '0;
    end else begin
      r_vld <= L'({r_vld, i_valid});
      for (int n = 1; n < P; n++) r_node[n] <= w_node[2*n] + w_node[2*n+1];
    end
  end
  assign o_last = r_vld[L-1];
  assign o_data = r_node[1];
endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: streaming P-lane masked multiply-accumulate with pipelined tree reduction
module dot_product_engine
  import dot_pkg::*;
#(
  parameter int DW    = 8,
  parameter int P     = 8,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              signed_mode,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [P*DW-1:0]   in_a,
  input  logic [P*DW-1:0]   in_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);
  state_t             r_state, w_next;
  logic               r_signed;
  logic [LEN_W-1:0]   r_rem;
  logic [P*ACC_W-1:0] w_acc_flat;
  logic               w_accept, w_xfer, w_last, w_tree_last;
  assign w_accept = (r_state == IDLE) && start;
  assign w_xfer   = in_valid && in_ready;
  assign w_last   = r_rem <= LEN_W'(P);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (len == '0 ? OUT : ACCUM) : IDLE;
      ACCUM:   w_next = (w_xfer && w_last) ? REDUCE : ACCUM;
      REDUCE:  w_next = w_tree_last ? OUT : REDUCE;
      OUT:     w_next = res_ready ? IDLE : OUT;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    busy      = r_state != IDLE;
    in_ready  = r_state == ACCUM;
    res_valid = r_state == OUT;
  end
  // r_rem counts elements still owed; once it drops to P or below, lanes at or above it are dead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem    <= '0;
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_rem    <= len;
      r_signed <= signed_mode;
    end else if (w_xfer) begin
      r_rem    <= w_last ? '0 : r_rem - LEN_W'(P);
    end
  end
  for (genvar i = 0; i < P; i++) begin : g_lane
    logic [DW-1:0]          w_a, w_b;
    logic signed [2*DW-1:0] w_ps;
    logic [2*DW-1:0]        w_pu;
    logic [ACC_W-1:0]       w_ext;
    logic                   w_live;
    logic [ACC_W-1:0]       r_acc;
    assign w_a    = in_a[lane_lsb(i, DW) +: DW];
    assign w_b    = in_b[lane_lsb(i, DW) +: DW];
    assign w_ps   = (2*DW)'($signed(w_a)) * (2*DW)'($signed(w_b));
    assign w_pu   = (2*DW)'(w_a) * (2*DW)'(w_b);
    assign w_ext  = r_signed ? ACC_W'(w_ps) : ACC_W'(w_pu);
    assign w_live = LEN_W'(i) < r_rem;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                 r_acc <= '0;
      else if (w_accept)         r_acc <= '0;
      else if (w_xfer && w_live) r_acc <= r_acc + w_ext;
    end
    assign w_acc_flat[lane_lsb(i, ACC_W) +: ACC_W] = r_acc;
  end
  adder_tree_pipe #(.P(P), .ACC_W(ACC_W)) u_tree (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_accept),
    .i_valid (w_xfer && w_last),
    .i_data  (w_acc_flat),
    .o_last  (w_tree_last),
    .o_data  (res_data)
  );
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: directed scenario tasks with hand-computed results for the dot-product engine
module tb_dot_product_engine;
  localparam int DW = 8, P = 8, ACC_W = 32, LEN_W = 16;
  logic clk = 0, reset = 1, start = 0, signed_mode = 0, in_valid = 0, res_ready = 0;
  logic [LEN_W-1:0] len = '0;
  logic [P*DW-1:0] in_a = '0, in_b = '0;
  logic busy, in_ready, res_valid;
  logic [ACC_W-1:0] res_data;
  logic s_start = 0, s_in_valid = 0;
  logic [15:0] s_len = '0, s_a = '0, s_b = '0;
  logic s_busy, s_in_ready, s_res_valid;
  logic [15:0] s_res_data;
  int n_cmp = 0, n_bad = 0;
  int ea [80];
  int eb [80];
  always #5 clk = ~clk;
  dot_product_engine #(.DW(DW), .P(P), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .signed_mode(signed_mode),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );
  dot_product_engine #(.DW(8), .P(2), .ACC_W(16), .LEN_W(16)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .len(s_len), .signed_mode(1'b0),
    .busy(s_busy), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_a), .in_b(s_b),
    .res_valid(s_res_valid), .res_ready(1'b1), .res_data(s_res_data)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill_ramp();
    for (int i = 0; i < 80; i++) begin
      ea[i] = i + 1;
      eb[i] = i + 1;
    end
  endtask
  task automatic fill_const(input int av, input int bv);
    for (int i = 0; i < 80; i++) begin
      ea[i] = av;
      eb[i] = bv;
    end
  endtask
  task automatic drive_beat(input int k, input int n);
    for (int i = 0; i < P; i++) begin
      int j;
      j = k * P + i;
      in_a[i*DW +: DW] = (in_valid && j < n) ? DW'(ea[j]) : 8'hFF;
      in_b[i*DW +: DW] = (in_valid && j < n) ? DW'(eb[j]) : 8'hFF;
    end
  endtask
  task automatic do_op(input int n, input bit sgn, input bit gap, input int pulse_cyc,
                       output int cyc, output int beats);
    int k;
    k = 0;
    len = LEN_W'(n);
    signed_mode = sgn;
    start = 1;
    tick();
    start = 0;
    cyc = 1;
    len = 16'hFFFF;
    signed_mode = ~sgn;
    while (res_valid !== 1'b1 && cyc < 300) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      start = (cyc == pulse_cyc);
      drive_beat(k, n);
      if (in_valid && in_ready) k++;
      tick();
      cyc++;
    end
    start = 0;
    in_valid = 0;
    beats = k;
    n_cmp++;
    if (res_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL op_timeout len=%0d: res_valid=%b after %0d cycles, required 1", n, res_valid, cyc);
    end
  endtask
  task automatic handshake(input bit with_start);
    res_ready = 1;
    start = with_start;
    len = 16'd5;
    tick();
    res_ready = 0;
    start = 0;
    n_cmp++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake_idle: busy=%b res_valid=%b, required 0/0", busy, res_valid);
    end
  endtask
  task automatic check_op(input string name, input int cyc, input int beats,
                          input logic [31:0] exp_res, input int exp_cyc, input int exp_beats);
    n_cmp += 3;
    if (res_data !== exp_res) begin
      n_bad++;
      $display("FAIL %s_data: got 0x%08h, required 0x%08h", name, res_data, exp_res);
    end
    if (cyc !== exp_cyc) begin
      n_bad++;
      $display("FAIL %s_latency: res_valid at cycle %0d, required %0d", name, cyc, exp_cyc);
    end
    if (beats !== exp_beats) begin
      n_bad++;
      $display("FAIL %s_beats: %0d transfers, required %0d", name, beats, exp_beats);
    end
  endtask
  task automatic test_reset();
    #3;
    n_cmp += 2;
    if ({busy, in_ready, res_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: busy/in_ready/res_valid=%b, required 000", {busy, in_ready, res_valid});
    end
    if (res_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_data: got 0x%08h, required 0", res_data);
    end
    tick();
    reset = 0;
    tick();
  endtask
  task automatic test_unsigned_full();
    int cyc, beats;
    fill_ramp();
    do_op(70, 0, 0, -1, cyc, beats);
    check_op("unsigned_full", cyc, beats, 32'd116795, 13, 9);
    handshake(0);
  endtask
  task automatic test_signed();
    int cyc, beats;
    fill_const(8'h80, 8'h7F);
    do_op(3, 1, 0, -1, cyc, beats);
    check_op("signed", cyc, beats, 32'hFFFF4180, 5, 1);
    handshake(0);
    do_op(3, 0, 0, -1, cyc, beats);
    check_op("unsigned_same", cyc, beats, 32'h0000BE80, 5, 1);
    handshake(0);
  endtask
  task automatic test_flow_control();
    int cyc, beats;
    fill_ramp();
    do_op(70, 0, 1, -1, cyc, beats);
    check_op("gapped", cyc, beats, 32'd116795, 22, 9);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (res_valid !== 1'b1 || res_data !== 32'd116795) begin
        n_bad++;
        $display("FAIL hold_out c=%0d: res_valid=%b data=%0d, required 1/116795", c, res_valid, res_data);
      end
    end
    handshake(0);
  endtask
  task automatic test_len_zero();
    int cyc, beats;
    do_op(0, 0, 0, -1, cyc, beats);
    check_op("len_zero", cyc, beats, 32'd0, 1, 0);
    handshake(0);
  endtask
  task automatic test_wrap16();
    int cyc;
    s_len = 16'd2;
    s_a = 16'hFFFF;
    s_b = 16'hFFFF;
    s_start = 1;
    tick();
    s_start = 0;
    s_in_valid = 1;
    cyc = 1;
    while (s_res_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
    s_in_valid = 0;
    n_cmp += 2;
    if (s_res_data !== 16'd64514) begin
      n_bad++;
      $display("FAIL wrap16_data: got %0d, required 64514", s_res_data);
    end
    if (cyc !== 3) begin
      n_bad++;
      $display("FAIL wrap16_latency: res_valid at cycle %0d, required 3", cyc);
    end
    tick();
  endtask
  task automatic test_reset_mid();
    int cyc, beats;
    fill_ramp();
    len = 16'd70;
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      drive_beat(k, 70);
      tick();
    end
    #2 reset = 1;
    #1;
    n_cmp += 2;
    if ({busy, in_ready, res_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset_flags: busy/in_ready/res_valid=%b, required 000", {busy, in_ready, res_valid});
    end
    if (res_data !== 32'd0) begin
      n_bad++;
      $display("FAIL midreset_data: got 0x%08h, required 0", res_data);
    end
    in_valid = 0;
    tick();
    reset = 0;
    tick();
    fill_const(1, 1);
    do_op(8, 0, 0, -1, cyc, beats);
    check_op("after_reset", cyc, beats, 32'd8, 5, 1);
    handshake(0);
  endtask
  task automatic test_start_while_busy();
    int cyc, beats;
    fill_ramp();
    do_op(70, 0, 0, 4, cyc, beats);
    check_op("busy_start", cyc, beats, 32'd116795, 13, 9);
    handshake(1);
    fill_const(1, 1);
    do_op(8, 0, 0, -1, cyc, beats);
    check_op("restart", cyc, beats, 32'd8, 5, 1);
    handshake(0);
  endtask
  initial begin
    test_reset();
    test_unsigned_full();
    test_signed();
    test_flow_control();
    test_len_zero();
    test_wrap16();
    test_reset_mid();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
